// File: rtl/pkt_rr_arbiter2.sv
// pkt_rr_arbiter2: two-input, packet-granular round-robin arbiter for the
// 134-bit pkt/valid stream. Each input is buffered in its own show-ahead
// pkt FIFO and valid-flag FIFO; whole packets are merged onto one output.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   inX_pkt_wr / inX_pkt       packet word strobe and 134-bit word
//                              ([133:132] 01 first, 11 middle, 10 last)
//   inX_valid_wr / inX_valid   per-packet keep(1)/discard(0) flag strobe
//   out_inX_pkt_almostfull     registered per-input FIFO almost-full
//   out_pkt_wr / out_pkt       registered downstream word strobe and word
//   out_valid_wr / out_valid   registered downstream flag strobe and flag
//   in_pkt_almostfull          downstream back-pressure, sampled in IDLE

// Show-ahead synchronous FIFO: dout_c presents the head entry whenever
// empty_c is low. Writes to a full FIFO are dropped unless a pop happens
// in the same cycle; pops of an empty FIFO are ignored.
module pkt_rr_arbiter2_fifo #(
  parameter int unsigned W  = 134,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic [W-1:0]  din,
  input  logic          rd,
  output logic [W-1:0]  dout_c,
  output logic          empty_c,
  output logic [AW:0]   count_q
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_d;
  logic          full_c;
  logic          wr_ok_c;
  logic          rd_ok_c;

  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == (AW+1)'(DEPTH));
  assign rd_ok_c = rd && !empty_c;
  // A pop in the same cycle frees the slot the write lands in.
  assign wr_ok_c = wr && (!full_c || rd_ok_c);
  assign dout_c  = mem_q[rd_ptr_q];

  // Pointer and fill-count next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok_c) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_ok_c, rd_ok_c})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and fill-count registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (wr_ok_c) mem_q[wr_ptr_q] <= din;
  end

endmodule

module pkt_rr_arbiter2 #(
  parameter int unsigned PKT_AW   = 8,
  parameter int unsigned VAL_AW   = 6,
  parameter int unsigned AF_LEVEL = 150
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in0_pkt_wr,
  input  logic [133:0] in0_pkt,
  input  logic         in0_valid_wr,
  input  logic         in0_valid,
  output logic         out_in0_pkt_almostfull,
  input  logic         in1_pkt_wr,
  input  logic [133:0] in1_pkt,
  input  logic         in1_valid_wr,
  input  logic         in1_valid,
  output logic         out_in1_pkt_almostfull,
  output logic         out_pkt_wr,
  output logic [133:0] out_pkt,
  output logic         out_valid_wr,
  output logic         out_valid,
  input  logic         in_pkt_almostfull
);

  localparam int unsigned PKT_W   = 134;
  localparam int unsigned HDR_MSB = PKT_W - 1;
  localparam logic [1:0]  HDR_LAST = 2'b10;
  localparam logic [PKT_AW:0] PKT_AF_TH = (PKT_AW+1)'(AF_LEVEL);
  localparam logic [VAL_AW:0] VAL_AF_TH = (VAL_AW+1)'((1 << VAL_AW) - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND0 = 2'd1,
    SEND1 = 2'd2
  } state_e;

  // FIFO interface signals, index 0/1 = input 0/1.
  logic [1:0][PKT_W-1:0] pkt_dout_c;
  logic [1:0]            pkt_empty_c;
  logic [1:0]            pkt_rd_c;
  logic [1:0]            val_dout_c;
  logic [1:0]            val_empty_c;
  logic [1:0]            val_rd_c;
  logic [PKT_AW:0]       pkt0_cnt, pkt1_cnt;
  logic [VAL_AW:0]       val0_cnt, val1_cnt;

  // Arbitration state.
  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  keep_q, keep_d;
  logic [1:0]            elig_c;
  logic                  sel_c;

  // Registered outputs.
  logic                  out_pkt_wr_q, out_pkt_wr_d;
  logic [PKT_W-1:0]      out_pkt_q, out_pkt_d;
  logic                  out_valid_wr_q, out_valid_wr_d;
  logic                  out_valid_q, out_valid_d;
  logic                  af0_q, af0_d;
  logic                  af1_q, af1_d;

  pkt_rr_arbiter2_fifo #(.W(PKT_W), .AW(PKT_AW)) u_pkt0 (
    .clk     (clk),
    .reset   (reset),
    .wr      (in0_pkt_wr),
    .din     (in0_pkt),
    .rd      (pkt_rd_c[0]),
    .dout_c  (pkt_dout_c[0]),
    .empty_c (pkt_empty_c[0]),
    .count_q (pkt0_cnt)
  );

  pkt_rr_arbiter2_fifo #(.W(PKT_W), .AW(PKT_AW)) u_pkt1 (
    .clk     (clk),
    .reset   (reset),
    .wr      (in1_pkt_wr),
    .din     (in1_pkt),
    .rd      (pkt_rd_c[1]),
    .dout_c  (pkt_dout_c[1]),
    .empty_c (pkt_empty_c[1]),
    .count_q (pkt1_cnt)
  );

  pkt_rr_arbiter2_fifo #(.W(1), .AW(VAL_AW)) u_val0 (
    .clk     (clk),
    .reset   (reset),
    .wr      (in0_valid_wr),
    .din     (in0_valid),
    .rd      (val_rd_c[0]),
    .dout_c  (val_dout_c[0]),
    .empty_c (val_empty_c[0]),
    .count_q (val0_cnt)
  );

  pkt_rr_arbiter2_fifo #(.W(1), .AW(VAL_AW)) u_val1 (
    .clk     (clk),
    .reset   (reset),
    .wr      (in1_valid_wr),
    .din     (in1_valid),
    .rd      (val_rd_c[1]),
    .dout_c  (val_dout_c[1]),
    .empty_c (val_empty_c[1]),
    .count_q (val1_cnt)
  );

  // An input may start a packet once its flag has arrived and downstream has room.
  assign elig_c = ~val_empty_c & {2{~in_pkt_almostfull}};

  // Almost-full from the current (registered) fill counts, so it lags one cycle.
  assign af0_d = (pkt0_cnt >= PKT_AF_TH) || (val0_cnt >= VAL_AF_TH);
  assign af1_d = (pkt1_cnt >= PKT_AF_TH) || (val1_cnt >= VAL_AF_TH);

  // Next-state, FIFO pops and output next values.
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    keep_d         = keep_q;
    out_pkt_d      = out_pkt_q;
    out_pkt_wr_d   = 1'b0;
    out_valid_wr_d = 1'b0;
    out_valid_d    = 1'b0;
    pkt_rd_c       = 2'b00;
    val_rd_c       = 2'b00;
    sel_c          = 1'b0;

    case (state_q)
      IDLE: begin
        if (elig_c != 2'b00) begin
          // On a tie the input that did not send last goes next.
          sel_c           = (elig_c == 2'b11) ? ~last_grant_q : elig_c[1];
          val_rd_c[sel_c] = 1'b1;
          keep_d          = val_dout_c[sel_c];
          state_d         = sel_c ? SEND1 : SEND0;
        end
      end

      SEND0, SEND1: begin
        sel_c = (state_q == SEND1);
        // An empty pkt FIFO mid-packet simply stalls here.
        if (!pkt_empty_c[sel_c]) begin
          pkt_rd_c[sel_c] = 1'b1;
          out_pkt_d       = pkt_dout_c[sel_c];
          out_pkt_wr_d    = keep_q;
          if (pkt_dout_c[sel_c][HDR_MSB -: 2] == HDR_LAST) begin
            out_valid_wr_d = keep_q;
            out_valid_d    = keep_q;
            last_grant_d   = sel_c;
            state_d        = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b1;
      keep_q         <= 1'b0;
      out_pkt_wr_q   <= 1'b0;
      out_pkt_q      <= '0;
      out_valid_wr_q <= 1'b0;
      out_valid_q    <= 1'b0;
      af0_q          <= 1'b0;
      af1_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      keep_q         <= keep_d;
      out_pkt_wr_q   <= out_pkt_wr_d;
      out_pkt_q      <= out_pkt_d;
      out_valid_wr_q <= out_valid_wr_d;
      out_valid_q    <= out_valid_d;
      af0_q          <= af0_d;
      af1_q          <= af1_d;
    end
  end

  assign out_pkt_wr             = out_pkt_wr_q;
  assign out_pkt                = out_pkt_q;
  assign out_valid_wr           = out_valid_wr_q;
  assign out_valid              = out_valid_q;
  assign out_in0_pkt_almostfull = af0_q;
  assign out_in1_pkt_almostfull = af1_q;

endmodule

// File: doc/pkt_rr_arbiter2.md
# pkt_rr_arbiter2

Two-input, packet-granular round-robin arbiter for the 134-bit pkt/valid stream format used throughout the IPE pipeline. It buffers each requester (e.g. the INGRESS→DISPATHER path and a CPU/PPC return path) in its own pkt and valid FIFOs and merges whole packets onto one downstream port, such as the RDMA or output-control interface. It honours per-packet discard flags and downstream almost-full back-pressure.

## Interface
- PKT_AW, 8: pkt FIFO address width per input (depth 2^PKT_AW words of 134 bits).
- VAL_AW, 6: valid FIFO address width per input (depth 2^VAL_AW flags).
- AF_LEVEL, 150: pkt FIFO fill (words) at or above which that input's almostfull asserts.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low; clears all state and FIFOs.
- in0_pkt_wr / in1_pkt_wr  in  1  write strobe for one packet word.
- in0_pkt / in1_pkt  in  134  word; [133:132] = 01 first, 11 middle, 10 last; [127:0] data.
- in0_valid_wr / in1_valid_wr  in  1  per-packet flag strobe, issued at or after the last word.
- in0_valid / in1_valid  in  1  1 = forward packet, 0 = discard.
- out_in0_pkt_almostfull / out_in1_pkt_almostfull  out  1  pkt FIFO fill ≥ AF_LEVEL or valid FIFO fill ≥ 2^VAL_AW−2.
- out_pkt_wr  out  1  downstream word strobe.
- out_pkt  out  134  downstream word.
- out_valid_wr  out  1  downstream flag strobe.
- out_valid  out  1  downstream flag; always 1 when strobed.
- in_pkt_almostfull  in  1  downstream back-pressure.

## Operation
- Per-input storage: show-ahead pkt FIFO and valid FIFO. A write to a full FIFO is ignored. No error output.
- State machine: IDLE, SEND0, SEND1.
- IDLE → SENDx when in_pkt_almostfull = 0 and valid FIFO x is non-empty. If both inputs are eligible, grant the input ≠ last_grant. last_grant resets to 1, so input 0 wins the first tie.
- On grant: pop valid FIFO x and latch keep = popped flag. If no input is eligible, stay in IDLE.
- SENDx: each cycle pkt FIFO x is non-empty, pop one word.
  - Register the word onto out_pkt.
  - Drive out_pkt_wr = keep.
- If pkt FIFO x is empty mid-packet: no pop, no write. Stall in SENDx.
- On popping a word with [133:132] = 10:
  - out_valid_wr = keep and out_valid = 1 on the same cycle as that word's out_pkt_wr.
  - Set last_grant = x. Return to IDLE.
- Discarded packets (keep = 0) are drained at one word per cycle with no output strobes. last_grant still updates.
- in_pkt_almostfull is sampled only in IDLE. A packet in progress always completes; the downstream margin covers a max-size packet.
- Header bits pass through unmodified. No reordering within an input.

## Timing
- Reset values: out_pkt_wr = 0, out_pkt = 0, out_valid_wr = 0, out_valid = 0. Both almostfull outputs = 0. State = IDLE, last_grant = 1, keep = 0, FIFOs empty.
- FIFO write to show-ahead visibility: 1 cycle.
- IDLE decision: 1 cycle. First output word appears 1 cycle after the pop.
- Latency, valid_wr at input (FIFO idle, pkt already stored) to first out_pkt_wr: 3 cycles.
- Throughput: 1 word/cycle within a packet, with exactly 1 bubble cycle (IDLE) between packets.
- almostfull outputs are registered from FIFO fill counts and lag by 1 cycle. AF_LEVEL leaves 2^PKT_AW − AF_LEVEL words of slack.
- Simultaneous write and pop on the same FIFO: fill unchanged, both take effect.
- Reset asserted mid-packet: outputs drop to reset values asynchronously. The partial packet is lost, never completed.

## Test plan
- Single 4-word keep packet on in0 (01,11,11,10): out_pkt_wr high for 4 consecutive cycles with identical words; out_valid_wr = 1 and out_valid = 1 with the 4th word; first write 3 cycles after in0_valid_wr.
- Both inputs hold 3 packets each, all valid = 1, ties present: output order in0,in1,in0,in1,in0,in1; one idle cycle between packets; no interleaved words.
- in1 packet with valid = 0 queued between two keep packets: the discarded packet's words never appear on output; the following packet starts after drain + 1 idle cycle.
- in_pkt_almostfull = 1 while both inputs are queued: no new packet starts. Assert it mid-packet: the current packet still completes. Deassert: next grant within 1 cycle.
- Fill in0 pkt FIFO to AF_LEVEL = 150 words with downstream blocked: out_in0_pkt_almostfull = 1 one cycle after the 150th write; 2^PKT_AW + 1 writes leave fill = 256 and drop the extra word.
- Assert reset low on 2nd word of a 6-word packet: all outputs 0 immediately. After release, a fresh packet on in0 forwards correctly with no residue.
